// File: rtl/sram_arb.sv
// sram_arb: two-requester arbiter in front of a single-port SRAM macro
// (OpenRAM-style: active-low csb/web, registered address, dout valid the
// cycle after the access).
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration between
// the two requesters. Left undefined, arbitration is fixed priority with
// port 0 winning every tie.
//
// Handshake rules (both request and response channels):
//   A transfer happens on a rising edge where valid=1 and ready=1 in the
//   cycle before it. A source holding valid=1 keeps its payload stable until
//   the transfer. pN_req_ready is a combinational function of eligibility
//   and arbitration only; request content is never buffered here, so any
//   payload change while ready=0 has no effect. pN_rsp_valid/pN_rsp_rdata
//   stay stable until accepted and valid drops on the accepting edge.
//
// Each port has a tracker FSM: IDLE -> ISSUED (grant edge) -> CAPTURE
// (macro data latched into the response register) -> IDLE. The state is
// exported on p0_state/p1_state (0=IDLE, 1=ISSUED, 2=CAPTURE).
module sram_arb #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    // requester 0
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [NUM_WMASKS-1:0] p0_req_wmask,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    input  logic                  p0_rsp_ready,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    // requester 1
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [NUM_WMASKS-1:0] p1_req_wmask,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    input  logic                  p1_rsp_ready,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    // SRAM macro port
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    // tracker state observation
    output logic [1:0]            p0_state,
    output logic [1:0]            p1_state
);

    typedef enum logic [1:0] {
        TRK_IDLE    = 2'd0,
        TRK_ISSUED  = 2'd1,
        TRK_CAPTURE = 2'd2
    } trk_state_t;

    // ------------------------------------------------------------------
    // Per-port views of the flat port list, so the two ports share logic
    // ------------------------------------------------------------------
    logic [1:0]            req_valid;
    logic [1:0]            req_we;
    logic [NUM_WMASKS-1:0] req_wmask [2];
    logic [ADDR_WIDTH-1:0] req_addr  [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];
    logic [1:0]            rsp_ready;

    assign req_valid    = {p1_req_valid, p0_req_valid};
    assign req_we       = {p1_req_we, p0_req_we};
    assign req_wmask[0] = p0_req_wmask;
    assign req_wmask[1] = p1_req_wmask;
    assign req_addr[0]  = p0_req_addr;
    assign req_addr[1]  = p1_req_addr;
    assign req_wdata[0] = p0_req_wdata;
    assign req_wdata[1] = p1_req_wdata;
    assign rsp_ready    = {p1_rsp_ready, p0_rsp_ready};

    // tracker state and decoded tracker outputs
    trk_state_t state_q [2];
    trk_state_t state_d [2];
    logic [1:0] in_flight;
    logic [1:0] capture_en;

    // arbitration
    logic [1:0] eligible;
    logic [1:0] win;
    logic [1:0] ready;
    logic [1:0] grant;

    // access kind remembered from the grant, used when shaping the response
    logic [1:0] we_q;

    // response registers
    logic [1:0]            rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q [2];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef SRAM_ARB_RR_EN
    // prio_q names the port that wins a tie; it moves away from whichever
    // port was just granted and stays put on idle cycles.
    logic prio_q;

    // Round-robin pointer update on grants only
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (grant[0]) begin
            prio_q <= 1'b1;
        end else if (grant[1]) begin
            prio_q <= 1'b0;
        end
    end

    // Eligibility and round-robin winner selection
    always_comb begin
        eligible = req_valid & ~in_flight & ~rsp_valid_q;
        win      = 2'b00;
        if (eligible[0] && eligible[1]) begin
            win = prio_q ? 2'b10 : 2'b01;
        end else begin
            win = eligible;
        end
    end
`else
    // Eligibility and fixed-priority winner selection (port 0 first)
    always_comb begin
        eligible = req_valid & ~in_flight & ~rsp_valid_q;
        win      = 2'b00;
        if (eligible[0]) begin
            win = 2'b01;
        end else if (eligible[1]) begin
            win = 2'b10;
        end
    end
`endif

    // Ready is forced low during reset so nothing reaches the macro
    always_comb begin
        ready = rst_n ? win : 2'b00;
        grant = ready & req_valid;
    end

    assign p0_req_ready = ready[0];
    assign p1_req_ready = ready[1];

    // ------------------------------------------------------------------
    // SRAM command: driven straight from the granted port, idle otherwise
    // ------------------------------------------------------------------
    // Macro command mux
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (grant[0]) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~req_we[0];
            sram_wmask0 = req_wmask[0];
            sram_addr0  = req_addr[0];
            sram_din0   = req_wdata[0];
        end else if (grant[1]) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~req_we[1];
            sram_wmask0 = req_wmask[1];
            sram_addr0  = req_addr[1];
            sram_din0   = req_wdata[1];
        end
    end

    // ------------------------------------------------------------------
    // In-flight trackers (one per port)
    // ------------------------------------------------------------------
    // Tracker state register; reset drops any access in flight
    always_ff @(posedge clk0) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                state_q[i] <= TRK_IDLE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Tracker next-state: one step per cycle once granted
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                TRK_IDLE:    if (grant[i]) state_d[i] = TRK_ISSUED;
                TRK_ISSUED:  state_d[i] = TRK_CAPTURE;
                TRK_CAPTURE: state_d[i] = TRK_IDLE;
                default:     state_d[i] = TRK_IDLE;
            endcase
        end
    end

    // Tracker outputs: busy flag and the "macro data is on dout now" strobe
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_flight[i]  = (state_q[i] != TRK_IDLE);
            capture_en[i] = (state_q[i] == TRK_ISSUED);
        end
    end

    assign p0_state = state_q[0];
    assign p1_state = state_q[1];

    // Remember read/write of the access each port has outstanding
    always_ff @(posedge clk0) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                we_q[i] <= 1'b0;
            end else if (grant[i]) begin
                we_q[i] <= req_we[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    // Load from the macro one cycle after the grant, hold until accepted.
    // Only one tracker can be in ISSUED at a time, so dout is unambiguous.
    always_ff @(posedge clk0) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                rsp_valid_q[i] <= 1'b0;
                rsp_rdata_q[i] <= '0;
            end else if (capture_en[i]) begin
                rsp_valid_q[i] <= 1'b1;
                rsp_rdata_q[i] <= we_q[i] ? '0 : sram_dout0;
            end else if (rsp_valid_q[i] && rsp_ready[i]) begin
                rsp_valid_q[i] <= 1'b0;
            end
        end
    end

    assign p0_rsp_valid = rsp_valid_q[0];
    assign p1_rsp_valid = rsp_valid_q[1];
    assign p0_rsp_rdata = rsp_rdata_q[0];
    assign p1_rsp_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: bench for sram_arb with a behavioural single-port SRAM macro,
// a reference memory and per-port expected-response queues.
// Define SRAM_ARB_RR_EN on both the RTL and this file for the round-robin build.
module tb_sram_arb;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MW = 4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic          p0_req_valid, p0_req_ready, p0_req_we;
    logic [MW-1:0] p0_req_wmask;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata;
    logic          p0_rsp_valid, p0_rsp_ready;
    logic [DW-1:0] p0_rsp_rdata;
    logic          p1_req_valid, p1_req_ready, p1_req_we;
    logic [MW-1:0] p1_req_wmask;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata;
    logic          p1_rsp_valid, p1_rsp_ready;
    logic [DW-1:0] p1_rsp_rdata;
    logic          sram_csb0, sram_web0;
    logic [MW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;
    logic [1:0]    p0_state, p1_state;

    sram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
        .clk0(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_wmask(p0_req_wmask), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_wmask(p1_req_wmask), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .p0_state(p0_state), .p1_state(p1_state)
    );

    // Behavioural macro: registered address, dout valid the following cycle
    logic [DW-1:0] mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < MW; b++)
                    if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end else begin
                sram_dout0 <= mem[sram_addr0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    int            grant_log[$];
    int            grant_cyc[$];
    int            checks = 0;
    int            errors = 0;

    // ------------------------------------------------------------------
    // Driver tasks (entered and left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic drive_req(input int port, input logic v, input logic we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [MW-1:0] wmask);
        if (port == 0) begin
            p0_req_valid = v; p0_req_we = we; p0_req_addr = addr;
            p0_req_wdata = wdata; p0_req_wmask = wmask;
        end else begin
            p1_req_valid = v; p1_req_we = we; p1_req_addr = addr;
            p1_req_wdata = wdata; p1_req_wmask = wmask;
        end
    endtask

    // Present one request, wait for its grant, push the expected response
    task automatic issue(input int port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [MW-1:0] wmask,
                         output int gcyc);
        logic          got;
        logic [DW-1:0] e;
        got  = 1'b0;
        gcyc = -1;
        drive_req(port, 1'b1, we, addr, wdata, wmask);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? p0_req_ready : p1_req_ready) begin
                got  = 1'b1;
                gcyc = cycle;
                checks++;
                if ({sram_csb0, sram_web0, sram_addr0, sram_din0, sram_wmask0} !==
                    {1'b0, ~we, addr, wdata, wmask}) begin
                    errors++;
                    $display("FAIL sram_cmd p%0d: got csb=%b web=%b addr=%h din=%h wm=%h required web=%b addr=%h din=%h wm=%h",
                             port, sram_csb0, sram_web0, sram_addr0, sram_din0, sram_wmask0,
                             ~we, addr, wdata, wmask);
                end
                if (we) begin
                    for (int b = 0; b < MW; b++)
                        if (wmask[b]) ref_mem[addr][8*b +: 8] = wdata[8*b +: 8];
                    e = '0;
                end else begin
                    e = ref_mem[addr];
                end
                if (port == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout p%0d: got no grant, required grant within 200 cycles", port);
        end
        @(posedge clk); #1;
        drive_req(port, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Wait for the next response on a port; report its cycle and data
    task automatic wait_rsp(input int port, output int rc, output logic [DW-1:0] rd);
        rc = -1;
        rd = '0;
        for (int i = 0; i < 50 && rc < 0; i++) begin
            @(negedge clk);
            if ((port == 0) ? p0_rsp_valid : p1_rsp_valid) begin
                rc = cycle;
                rd = (port == 0) ? p0_rsp_rdata : p1_rsp_rdata;
            end
        end
        checks++;
        if (rc < 0) begin
            errors++;
            $display("FAIL rsp_timeout p%0d: got no response, required one within 50 cycles", port);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_op(input int port);
        int g;
        issue(port, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
              4'($urandom_range(0, 15)), g);
    endtask

    // ------------------------------------------------------------------
    // Monitor: scoreboard compare on accept, hold check, grant logging
    // ------------------------------------------------------------------
    task automatic monitor();
        logic [1:0]    pv = 2'b00;
        logic [1:0]    pr = 2'b00;
        logic [DW-1:0] pd [2];
        logic [1:0]    v, r;
        logic [DW-1:0] d [2];
        logic [DW-1:0] e;
        pd[0] = '0; pd[1] = '0;
        forever begin
            @(negedge clk);
            v    = {p1_rsp_valid, p0_rsp_valid};
            r    = {p1_rsp_ready, p0_rsp_ready};
            d[0] = p0_rsp_rdata;
            d[1] = p1_rsp_rdata;
            for (int p = 0; p < 2; p++) begin
                if (pv[p] && !pr[p] && rst_n) begin
                    checks++;
                    if (v[p] !== 1'b1 || d[p] !== pd[p]) begin
                        errors++;
                        $display("FAIL rsp_hold p%0d: got valid=%b data=%h required valid=1 data=%h",
                                 p, v[p], d[p], pd[p]);
                    end
                end
                if (v[p] && r[p]) begin
                    checks++;
                    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                        errors++;
                        $display("FAIL rsp_unexpected p%0d: got data=%h, required no response", p, d[p]);
                    end else begin
                        e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (d[p] !== e) begin
                            errors++;
                            $display("FAIL rsp_data p%0d: got %h required %h", p, d[p], e);
                        end
                    end
                end
            end
            pv = v; pr = r; pd[0] = d[0]; pd[1] = d[1];
            if ((p0_req_valid && p0_req_ready) || (p1_req_valid && p1_req_ready)) begin
                checks++;
                if (p0_req_valid && p0_req_ready && p1_req_valid && p1_req_ready) begin
                    errors++;
                    $display("FAIL one_grant: got two grants in cycle %0d, required at most one", cycle);
                end
                grant_log.push_back((p0_req_valid && p0_req_ready) ? 0 : 1);
                grant_cyc.push_back(cycle);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_req(0, 1'b1, 1'b1, 8'h33, 32'h1234_5678, 4'hF);
        drive_req(1, 1'b1, 1'b0, 8'h44, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({p0_req_ready, p1_req_ready, sram_csb0} !== 3'b001) begin
            errors++;
            $display("FAIL reset_ready_csb: got rdy0=%b rdy1=%b csb=%b required 0 0 1",
                     p0_req_ready, p1_req_ready, sram_csb0);
        end
        checks++;
        if ({sram_web0, sram_addr0, sram_din0, sram_wmask0} !== {1'b1, {(AW+DW+MW){1'b0}}}) begin
            errors++;
            $display("FAIL reset_sram_idle: got web=%b addr=%h din=%h wm=%h required 1 0 0 0",
                     sram_web0, sram_addr0, sram_din0, sram_wmask0);
        end
        checks++;
        if ({p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata, p1_rsp_rdata, p0_state, p1_state} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got v0=%b v1=%b d0=%h d1=%h s0=%0d s1=%0d required all zero",
                     p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata, p1_rsp_rdata, p0_state, p1_state);
        end
        @(posedge clk); #1;
        drive_req(0, 1'b0, 1'b0, '0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (sram_csb0 !== 1'b1) begin
            errors++;
            $display("FAIL idle_csb: got %b required 1", sram_csb0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int g, rc;
        logic [DW-1:0] rd;
        issue(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, g);
        wait_rsp(0, rc, rd);
        checks++;
        if (rc != g + 2 || rd !== '0) begin
            errors++;
            $display("FAIL write_rsp: got cycle=%0d data=%h required cycle=%0d data=0", rc, rd, g + 2);
        end
        issue(0, 1'b0, 8'h10, '0, '0, g);
        wait_rsp(0, rc, rd);
        checks++;
        if (rc != g + 2 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_rsp: got cycle=%0d data=%h required cycle=%0d data=deadbeef", rc, rd, g + 2);
        end
    endtask

    task automatic test_byte_mask();
        int g, rc;
        logic [DW-1:0] rd;
        issue(1, 1'b1, 8'h20, 32'h1122_3344, 4'h5, g);
        wait_rsp(1, rc, rd);
        issue(1, 1'b0, 8'h20, '0, '0, g);
        wait_rsp(1, rc, rd);
        checks++;
        if (rc != g + 2 || rd !== 32'h0022_0044) begin
            errors++;
            $display("FAIL byte_mask: got cycle=%0d data=%h required cycle=%0d data=00220044", rc, rd, g + 2);
        end
    endtask

    task automatic test_back_to_back();
        int g0, g1, g2;
        issue(0, 1'b0, 8'h10, '0, '0, g0);
        issue(0, 1'b0, 8'h20, '0, '0, g1);
        issue(0, 1'b0, 8'h05, '0, '0, g2);
        checks++;
        if (g1 - g0 != 3 || g2 - g1 != 3) begin
            errors++;
            $display("FAIL single_port_rate: got gaps %0d %0d required 3 3", g1 - g0, g2 - g1);
        end
        idle(4);
    endtask

    task automatic test_alternate();
        int first;
`ifdef SRAM_ARB_RR_EN
        first = 1;  // port 0 was granted last
`else
        first = 0;
`endif
        grant_log.delete();
        grant_cyc.delete();
        fork
            for (int k = 0; k < 4; k++) begin int g; issue(0, 1'b0, 8'($urandom_range(0, 31)), '0, '0, g); end
            for (int k = 0; k < 4; k++) begin int g; issue(1, 1'b0, 8'($urandom_range(0, 31)), '0, '0, g); end
        join
        idle(4);
        checks++;
        if (grant_log.size() != 8) begin
            errors++;
            $display("FAIL alt_count: got %0d grants required 8", grant_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (grant_log[i] != (first ^ (i % 2))) begin
                    errors++;
                    $display("FAIL alt_order[%0d]: got p%0d required p%0d", i, grant_log[i], first ^ (i % 2));
                end
            end
            checks++;
            if (grant_cyc[7] - grant_cyc[0] != 10) begin
                errors++;
                $display("FAIL alt_span: got %0d cycles required 10", grant_cyc[7] - grant_cyc[0]);
            end
        end
    endtask

    task automatic test_tie();
        int g, rc, exp_first;
        logic [DW-1:0] rd;
        for (int lead = 0; lead < 2; lead++) begin
            issue(lead, 1'b0, 8'h05, '0, '0, g);
            wait_rsp(lead, rc, rd);
`ifdef SRAM_ARB_RR_EN
            exp_first = 1 - lead;
`else
            exp_first = 0;
`endif
            grant_log.delete();
            fork
                begin int g0; issue(0, 1'b0, 8'h10, '0, '0, g0); end
                begin int g1; issue(1, 1'b0, 8'h20, '0, '0, g1); end
            join
            idle(5);
            checks++;
            if (grant_log.size() < 1 || grant_log[0] != exp_first) begin
                errors++;
                $display("FAIL tie_winner lead=p%0d: got p%0d required p%0d", lead,
                         (grant_log.size() < 1) ? -1 : grant_log[0], exp_first);
            end
        end
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                fork
                    for (int k = 0; k < 10; k++) rand_op(0);
                    for (int k = 0; k < 10; k++) rand_op(1);
                join
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk); #1;
                p0_rsp_ready = 1'($urandom_range(0, 1));
                p1_rsp_ready = 1'($urandom_range(0, 1));
            end
        join
        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
        idle(6);
    endtask

    task automatic test_stall();
        int g, gp, start;
        logic got;
        logic [DW-1:0] exp5, held;
        p0_rsp_ready = 1'b0;
        exp5 = ref_mem[5];
        issue(0, 1'b0, 8'h05, '0, '0, g);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (p0_rsp_valid) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL stall_rsp: got no p0 response, required one");
        end
        held  = p0_rsp_rdata;
        start = cycle;
        checks++;
        if (held !== exp5) begin
            errors++;
            $display("FAIL stall_data: got %h required %h", held, exp5);
        end
        gp = -1;
        fork
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== held || p0_req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: got valid=%b data=%h rdy=%b required 1 %h 0",
                             i, p0_rsp_valid, p0_rsp_rdata, p0_req_ready, held);
                end
                @(posedge clk); #1;
                drive_req(0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), $urandom, 4'($urandom_range(0, 15)));
                @(negedge clk);
            end
            begin
                @(posedge clk); #1;
                issue(1, 1'b0, 8'h10, '0, '0, gp);
                issue(1, 1'b0, 8'h20, '0, '0, gp);
            end
        join
        checks++;
        if (gp < 0 || gp > start + 9) begin
            errors++;
            $display("FAIL stall_other_port: got p1 grant cycle %0d required within %0d..%0d", gp, start, start + 9);
        end
        @(posedge clk); #1;
        drive_req(0, 1'b0, 1'b0, '0, '0, '0);
        p0_rsp_ready = 1'b1;
        idle(4);
    endtask

    task automatic test_reset_mid();
        int g;
        issue(0, 1'b0, 8'h10, '0, '0, g);
        rst_n = 1'b0;
        drive_req(0, 1'b1, 1'b0, 8'h20, '0, '0);
        drive_req(1, 1'b1, 1'b0, 8'h20, '0, '0);
        @(negedge clk);
        checks++;
        if ({sram_csb0, p0_req_ready, p1_req_ready} !== 3'b100) begin
            errors++;
            $display("FAIL midreset_block: got csb=%b rdy0=%b rdy1=%b required 1 0 0",
                     sram_csb0, p0_req_ready, p1_req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_req(0, 1'b0, 1'b0, '0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0, '0);
        exp_q0.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (p0_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_rsp[%0d]: got valid=%b required 0", i, p0_rsp_valid);
            end
        end
        @(posedge clk); #1;
        grant_log.delete();
        fork
            begin int g0; issue(0, 1'b0, 8'h10, '0, '0, g0); end
            begin int g1; issue(1, 1'b0, 8'h20, '0, '0, g1); end
        join
        idle(5);
        checks++;
        if (grant_log.size() < 1 || grant_log[0] != 0) begin
            errors++;
            $display("FAIL post_reset_first_grant: got p%0d required p0",
                     (grant_log.size() < 1) ? -1 : grant_log[0]);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        rst_n        = 1'b0;
        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
        drive_req(0, 1'b0, 1'b0, '0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0, '0);
        fork
            monitor();
        join_none

        test_reset();
        test_write_read();
        test_byte_mask();
        test_back_to_back();
        test_alternate();
        test_tie();
        test_random();
        test_stall();
        test_reset_mid();

        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d responses outstanding required 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
